result_manager: RTL and testbench

Writeback and PC-update stage directly downstream of the decoder/executer pair. Accepts one decoded instruction per handshake, together with its ALU result and branch flag. Commits it by writing the architectural register file, driving a single-port data-memory request for loads/stores, and advancing the program counter. Owns R0..R31 and program_counter, which feed back into the decoder and fetch.

---
 rtl/result_pkg.sv | 24 ++
 rtl/reg_file32.sv | 19 +
 rtl/result_manager.sv | 148 ++++++++++++++
 tb/tb_result_manager.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared commit-action encodings and writeback FSM states for the result stage.
package result_pkg;

  localparam logic [2:0] RES_NOP    = 3'b000;
  localparam logic [2:0] RES_ALU    = 3'b001;
  localparam logic [2:0] RES_J      = 3'b010;
  localparam logic [2:0] RES_JR     = 3'b011;
  localparam logic [2:0] RES_LW     = 3'b100;
  localparam logic [2:0] RES_SW     = 3'b101;
  localparam logic [2:0] RES_JAL    = 3'b110;
  localparam logic [2:0] RES_BRANCH = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Word offsets arrive as 26-bit two's complement.
  function automatic logic [31:0] sext_off(input logic [25:0] off);
    return {{6{off[25]}}, off};
  endfunction

endpackage

// File: rtl/reg_file32.sv
// 32x32 architectural register file: one synchronous write port, R0 hard-wired to zero.
module reg_file32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] regs [32]
);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/result_manager.sv
// Writeback / PC-update stage: commits one decoded instruction per handshake,
// owns the register file and program counter, and sequences data-memory accesses.
module result_manager
  import result_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic        exitCode,
  input  logic [2:0]  result_opcode,
  input  logic [4:0]  reg_d,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  input  logic [25:0] pc_increment_jump,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] program_counter,
  output logic [31:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
  output logic [31:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
  output logic [31:0] R16, R17, R18, R19, R20, R21, R22, R23,
  output logic [31:0] R24, R25, R26, R27, R28, R29, R30, R31,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  // Handshake: an instruction transfers on a rising edge where valid && ready.
  // ready is a pure function of state (high only in IDLE) and never depends on valid.
  state_t      state;
  logic [31:0] pc;
  logic [4:0]  mem_rd;
  logic [31:0] regs [32];
  logic        take;
  logic [31:0] off;
  logic [31:0] next_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign ready           = (state == IDLE);
  assign halted          = (state == HALT);
  assign state_dbg       = state;
  assign program_counter = pc;
  assign take            = valid && ready;
  assign off             = sext_off(pc_increment_jump);

  always_comb begin
    next_pc = pc + 32'd1;
    case (result_opcode)
      RES_J, RES_JAL: next_pc = pc + off;
      RES_JR:         next_pc = regs[reg_d];
      RES_BRANCH:     next_pc = alu_flag ? (pc + off) : (pc + 32'd1);
      default:        next_pc = pc + 32'd1;
    endcase
  end

  // Single write port shared by ALU results, JAL links and load returns.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = reg_d;
    rf_wdata = alu_result;
    if (take && !exitCode) begin
      if (result_opcode == RES_ALU) begin
        rf_we = 1'b1;
      end else if (result_opcode == RES_JAL) begin
        rf_we    = 1'b1;
        rf_waddr = LINK_REG;
        rf_wdata = pc + 32'd1;
      end
    end else if ((state == MEM) && mem_ack && !mem_we) begin
      rf_we    = 1'b1;
      rf_waddr = mem_rd;
      rf_wdata = mem_rdata;
    end
  end

  reg_file32 u_rf (
    .clk   (CLOCK_50),
    .reset (reset),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .regs  (regs)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= '0;
      retire    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            if (exitCode) begin
              state  <= HALT;
              retire <= 1'b1;
            end else if ((result_opcode == RES_LW) || (result_opcode == RES_SW)) begin
              mem_req   <= 1'b1;
              mem_we    <= (result_opcode == RES_SW);
              mem_addr  <= alu_result;
              mem_wdata <= regs[reg_d];
              mem_rd    <= reg_d;
              state     <= MEM;
            end else begin
              pc     <= next_pc;
              retire <= 1'b1;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            pc      <= pc + 32'd1;
            retire  <= 1'b1;
            state   <= IDLE;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign R0  = regs[0];  assign R1  = regs[1];  assign R2  = regs[2];  assign R3  = regs[3];
  assign R4  = regs[4];  assign R5  = regs[5];  assign R6  = regs[6];  assign R7  = regs[7];
  assign R8  = regs[8];  assign R9  = regs[9];  assign R10 = regs[10]; assign R11 = regs[11];
  assign R12 = regs[12]; assign R13 = regs[13]; assign R14 = regs[14]; assign R15 = regs[15];
  assign R16 = regs[16]; assign R17 = regs[17]; assign R18 = regs[18]; assign R19 = regs[19];
  assign R20 = regs[20]; assign R21 = regs[21]; assign R22 = regs[22]; assign R23 = regs[23];
  assign R24 = regs[24]; assign R25 = regs[25]; assign R26 = regs[26]; assign R27 = regs[27];
  assign R28 = regs[28]; assign R29 = regs[29]; assign R30 = regs[30]; assign R31 = regs[31];

endmodule

// File: tb/tb_result_manager.sv
// Bench for result_manager: vector table for single-cycle commits, hand sequences for
// memory waits, reset during MEM and halt; retire/PC pairs checked through a queue.
module tb_result_manager;
  import result_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic        exitCode = 1'b0;
  logic [2:0]  result_opcode = RES_NOP;
  logic [4:0]  reg_d = '0;
  logic [31:0] alu_result = '0;
  logic        alu_flag = 1'b0;
  logic [25:0] pc_increment_jump = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] program_counter;
  logic [31:0] r_out [32];
  logic        retire, halted;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  always #10 CLOCK_50 = ~CLOCK_50;

  result_manager #(.RESET_PC(32'd0), .LINK_REG(5'd31)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .valid(valid), .ready(ready), .exitCode(exitCode),
    .result_opcode(result_opcode), .reg_d(reg_d), .alu_result(alu_result), .alu_flag(alu_flag),
    .pc_increment_jump(pc_increment_jump), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .program_counter(program_counter),
    .R0(r_out[0]),   .R1(r_out[1]),   .R2(r_out[2]),   .R3(r_out[3]),
    .R4(r_out[4]),   .R5(r_out[5]),   .R6(r_out[6]),   .R7(r_out[7]),
    .R8(r_out[8]),   .R9(r_out[9]),   .R10(r_out[10]), .R11(r_out[11]),
    .R12(r_out[12]), .R13(r_out[13]), .R14(r_out[14]), .R15(r_out[15]),
    .R16(r_out[16]), .R17(r_out[17]), .R18(r_out[18]), .R19(r_out[19]),
    .R20(r_out[20]), .R21(r_out[21]), .R22(r_out[22]), .R23(r_out[23]),
    .R24(r_out[24]), .R25(r_out[25]), .R26(r_out[26]), .R27(r_out[27]),
    .R28(r_out[28]), .R29(r_out[29]), .R30(r_out[30]), .R31(r_out[31]),
    .retire(retire), .halted(halted), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every retire pulse must match the oldest outstanding expected PC.
  always @(negedge CLOCK_50) begin
    if (!reset && retire) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 32'd1, 32'd0);
      end else begin
        check("retire_pc", program_counter, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        flag;
    logic [25:0] off;
    logic [31:0] exp_pc;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  vec_t tv [17];

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] alu,
                       input logic flag, input logic [25:0] off);
    valid = 1'b1; result_opcode = op; reg_d = rd; alu_result = alu;
    alu_flag = flag; pc_increment_jump = off;
  endtask

  initial begin
    tv[0]  = '{RES_ALU,    5'd5,  32'hDEAD_BEEF, 1'b0, 26'd0,         32'd1,  5,  32'hDEAD_BEEF};
    tv[1]  = '{RES_ALU,    5'd0,  32'd7,         1'b0, 26'd0,         32'd2,  0,  32'd0};
    tv[2]  = '{RES_J,      5'd0,  32'd0,         1'b0, 26'd8,         32'd10, 5,  32'hDEAD_BEEF};
    tv[3]  = '{RES_J,      5'd0,  32'd0,         1'b0, 26'h3FFFFFC,   32'd6,  0,  32'd0};
    tv[4]  = '{RES_J,      5'd0,  32'd0,         1'b0, 26'd4,         32'd10, 0,  32'd0};
    tv[5]  = '{RES_BRANCH, 5'd0,  32'd0,         1'b0, 26'd100,       32'd11, 0,  32'd0};
    tv[6]  = '{RES_J,      5'd0,  32'd0,         1'b0, 26'h3FFFFFF,   32'd10, 0,  32'd0};
    tv[7]  = '{RES_BRANCH, 5'd0,  32'd0,         1'b1, 26'd3,         32'd13, 0,  32'd0};
    tv[8]  = '{RES_J,      5'd0,  32'd0,         1'b0, 26'd7,         32'd20, 0,  32'd0};
    tv[9]  = '{RES_JAL,    5'd0,  32'd0,         1'b0, 26'd5,         32'd25, 31, 32'd21};
    tv[10] = '{RES_JR,     5'd31, 32'd0,         1'b0, 26'd0,         32'd21, 31, 32'd21};
    tv[11] = '{RES_NOP,    5'd9,  32'd99,        1'b0, 26'd0,         32'd22, 9,  32'd0};
    tv[12] = '{RES_ALU,    5'd4,  32'h55,        1'b0, 26'd0,         32'd23, 4,  32'h55};
    tv[13] = '{RES_J,      5'd0,  32'd0,         1'b0, 26'h3FFFFE8,   32'hFFFF_FFFF, 0, 32'd0};
    tv[14] = '{RES_NOP,    5'd0,  32'd0,         1'b0, 26'd0,         32'd0,  0,  32'd0};
    tv[15] = '{RES_JAL,    5'd0,  32'd0,         1'b0, 26'd1,         32'd1,  31, 32'd1};
    tv[16] = '{RES_JR,     5'd4,  32'd0,         1'b0, 26'd0,         32'h55, 4,  32'h55};

    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_pc", program_counter, 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 32; i += 7) check($sformatf("rst_r%0d", i), r_out[i], 32'd0);

    // Back-to-back single-cycle commits, valid held high throughout.
    for (int i = 0; i < 17; i++) begin
      @(negedge CLOCK_50);
      drive(tv[i].op, tv[i].rd, tv[i].alu, tv[i].flag, tv[i].off);
      exp_q.push_back(tv[i].exp_pc);
      @(posedge CLOCK_50);
      #1;
      check($sformatf("vec%0d_pc", i), program_counter, tv[i].exp_pc);
      check($sformatf("vec%0d_r%0d", i, tv[i].chk_idx), r_out[tv[i].chk_idx], tv[i].chk_val);
      check($sformatf("vec%0d_retire", i), 32'(retire), 32'd1);
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'd1);
    end

    // LW with three wait cycles.
    @(negedge CLOCK_50);
    drive(RES_LW, 5'd3, 32'h40, 1'b0, 26'd0);
    exp_q.push_back(32'h56);
    @(posedge CLOCK_50);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLOCK_50);
      valid = 1'b0;
      check($sformatf("lw_req_c%0d", c), 32'(mem_req), 32'd1);
      check($sformatf("lw_addr_c%0d", c), mem_addr, 32'h40);
      check($sformatf("lw_we_c%0d", c), 32'(mem_we), 32'd0);
      check($sformatf("lw_ready_c%0d", c), 32'(ready), 32'd0);
      check($sformatf("lw_state_c%0d", c), 32'(state_dbg), 32'(MEM));
      check($sformatf("lw_pc_c%0d", c), program_counter, 32'h55);
      mem_ack = (c == 3);
      mem_rdata = 32'h1234;
    end
    @(negedge CLOCK_50);
    mem_ack = 1'b0;
    check("lw_req_drop", 32'(mem_req), 32'd0);
    check("lw_r3", r_out[3], 32'h1234);
    check("lw_ready_back", 32'(ready), 32'd1);

    // SW acknowledged in its first MEM cycle.
    drive(RES_SW, 5'd4, 32'h80, 1'b0, 26'd0);
    exp_q.push_back(32'h57);
    @(negedge CLOCK_50);
    valid = 1'b0;
    check("sw_req", 32'(mem_req), 32'd1);
    check("sw_we", 32'(mem_we), 32'd1);
    check("sw_wdata", mem_wdata, 32'h55);
    check("sw_addr", mem_addr, 32'h80);
    mem_ack = 1'b1;
    @(negedge CLOCK_50);
    mem_ack = 1'b0;
    check("sw_req_drop", 32'(mem_req), 32'd0);
    check("sw_pc", program_counter, 32'h57);

    // Reset arrives in the same cycle as a load acknowledge.
    drive(RES_LW, 5'd5, 32'h10, 1'b0, 26'd0);
    exp_q.push_back(32'h58);
    @(negedge CLOCK_50);
    valid = 1'b0;
    check("rstmem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD;
    @(posedge CLOCK_50);
    #1;
    exp_q.delete();
    check("rstmem_req", 32'(mem_req), 32'd0);
    check("rstmem_r5", r_out[5], 32'd0);
    check("rstmem_pc", program_counter, 32'd0);
    check("rstmem_ready", 32'(ready), 32'd1);
    check("rstmem_retire", 32'(retire), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    mem_ack = 1'b0;

    // Halt, then confirm valid and mem_ack are ignored.
    drive(RES_J, 5'd0, 32'd0, 1'b0, 26'd9);
    exp_q.push_back(32'd9);
    @(posedge CLOCK_50);
    #1;
    check("pre_halt_pc", program_counter, 32'd9);
    @(negedge CLOCK_50);
    exitCode = 1'b1;
    exp_q.push_back(32'd9);
    @(posedge CLOCK_50);
    #1;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_ready", 32'(ready), 32'd0);
    check("halt_pc", program_counter, 32'd9);
    check("halt_state", 32'(state_dbg), 32'(HALT));
    @(negedge CLOCK_50);
    exitCode = 1'b0;
    drive(RES_ALU, 5'd6, 32'h77, 1'b0, 26'd5);
    mem_ack = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("halt_pc_frozen", program_counter, 32'd9);
    check("halt_r6", r_out[6], 32'd0);
    check("halt_still", 32'(halted), 32'd1);
    check("halt_mem_req", 32'(mem_req), 32'd0);
    @(negedge CLOCK_50);
    valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge CLOCK_50);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
